// File: rtl/div_pkg.sv
// Shared types and constants for the serial restoring divider.
// Imported by serial_div and its testbench-facing top.
package div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_t;

   localparam int DIV_ITER = 32;
   localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the quotient bit.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic         msb,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic         q_bit
);

   logic [W:0]   shifted;
   logic [W-1:0] diff;

   // rem < divisor on entry, so a fitting difference always fits in W bits
   always_comb begin
      shifted  = {rem, msb};
      q_bit    = shifted >= {1'b0, divisor};
      diff     = shifted[W-1:0] - divisor;
      rem_next = q_bit ? diff : shifted[W-1:0];
   end

endmodule

// File: rtl/serial_div.sv
// Multi-cycle radix-2 restoring divider answering the ALU start/annul/ready
// handshake; result is {remainder, quotient}.
module serial_div
   import div_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              signed_div_i,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              start_i,
   input  logic              annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic              ready_o
);

   localparam int ITER = DATA_W;
   localparam int CW   = $clog2(ITER);

   div_state_t state, state_nx;

   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] dvd;
   logic [DATA_W-1:0] dsr;
   logic              sign_q;
   logic              sign_r;
   logic              zero;
   logic [2*DATA_W-1:0] result;

   logic [DATA_W-1:0] abs_a;
   logic [DATA_W-1:0] abs_b;
   logic [DATA_W-1:0] rem_nx;
   logic              q_bit;
   logic [DATA_W-1:0] quot_fin;
   logic [DATA_W-1:0] q_fix;
   logic [DATA_W-1:0] r_fix;
   logic              last;
   logic              take;

   div_step #(.W(DATA_W)) u_step (
      .rem      (rem),
      .msb      (dvd[DATA_W-1]),
      .divisor  (dsr),
      .rem_next (rem_nx),
      .q_bit    (q_bit)
   );

   always_comb begin
      take     = start_i && !annul_i;
      abs_a    = (signed_div_i && a[DATA_W-1]) ? -a : a;
      abs_b    = (signed_div_i && b[DATA_W-1]) ? -b : b;
      quot_fin = {dvd[DATA_W-2:0], q_bit};
      q_fix    = sign_q ? -quot_fin : quot_fin;
      r_fix    = sign_r ? -rem_nx : rem_nx;
      last     = cnt == CW'(ITER - 1);
   end

   // b = 0 skips the loop and resolves on the first BUSY edge
   always_comb begin
      state_nx = state;
      unique case (state)
         DIV_IDLE: if (take) state_nx = DIV_BUSY;
         DIV_BUSY: begin
            if (annul_i)
               state_nx = DIV_IDLE;
            else if (zero || last)
               state_nx = DIV_DONE;
         end
         DIV_DONE: state_nx = DIV_IDLE;
         default:  state_nx = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= DIV_IDLE;
         cnt    <= '0;
         rem    <= '0;
         dvd    <= '0;
         dsr    <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         zero   <= 1'b0;
         result <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            DIV_IDLE: begin
               if (take) begin
                  cnt    <= '0;
                  dsr    <= abs_b;
                  zero   <= b == '0;
                  sign_q <= signed_div_i && (a[DATA_W-1] ^ b[DATA_W-1]);
                  sign_r <= signed_div_i && a[DATA_W-1];
                  if (b == '0) begin
                     rem <= a;
                     dvd <= DATA_W'(DIV_ZERO_QUOT);
                  end else begin
                     rem <= '0;
                     dvd <= abs_a;
                  end
               end
            end
            DIV_BUSY: begin
               if (!annul_i) begin
                  if (zero) begin
                     result <= {rem, dvd};
                  end else begin
                     rem <= rem_nx;
                     dvd <= quot_fin;
                     cnt <= cnt + CW'(1);
                     if (last) result <= {r_fix, q_fix};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o  = state == DIV_DONE;
   assign result_o = result;

endmodule

// File: tb/tb_serial_div.sv
// Self-checking bench for serial_div against an arithmetic reference.
module tb_serial_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] a;
   logic [31:0] b;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks;
   int errors;

   serial_div #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .a            (a),
      .b            (b),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic s,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] qv, rv;
      if (y == 0) return {x, 32'hFFFFFFFF};
      if (!s) return {x % y, x / y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   // called at a negedge; start is sampled on the following posedge (E0)
   task automatic run_div(input string tag, input logic s,
                          input logic [31:0] x, input logic [31:0] y);
      logic [63:0] exp;
      int got;
      int lat;
      exp = ref_div(s, x, y);
      lat = (y == 0) ? 1 : 32;
      signed_div_i = s;
      a = x;
      b = y;
      start_i = 1'b1;
      got = -1;
      for (int k = 0; k <= 40; k++) begin
         @(negedge clk);
         if (ready_o) begin
            got = k;
            break;
         end
      end
      start_i = 1'b0;
      check({tag, "_lat"}, 64'(got), 64'(lat));
      check({tag, "_res"}, result_o, exp);
      @(negedge clk);
      check({tag, "_one"}, 64'(ready_o), 64'd0);
   endtask

   initial begin
      logic [63:0] prev;
      int hits;
      checks = 0;
      errors = 0;
      rst = 1'b0;
      signed_div_i = 1'b0;
      a = '0;
      b = '0;
      start_i = 1'b0;
      annul_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ready_o), 64'd0);
      check("rst_result", result_o, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      run_div("u100_7", 1'b0, 32'd100, 32'd7);
      check("u100_7_val", result_o, {32'd2, 32'd14});
      run_div("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
      check("sm7_2_val", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
      run_div("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
      check("s7_m2_val", result_o, {32'd1, 32'hFFFFFFFD});
      run_div("sovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
      check("sovf_val", result_o, {32'd0, 32'h80000000});
      run_div("uovf", 1'b0, 32'h80000000, 32'hFFFFFFFF);
      check("uovf_val", result_o, {32'h80000000, 32'd0});
      run_div("uz", 1'b0, 32'd5, 32'd0);
      check("uz_val", result_o, {32'd5, 32'hFFFFFFFF});
      run_div("sz", 1'b1, 32'd5, 32'd0);
      check("sz_val", result_o, {32'd5, 32'hFFFFFFFF});

      // annul at E10
      prev = result_o;
      signed_div_i = 1'b0;
      a = 32'd50;
      b = 32'd7;
      start_i = 1'b1;
      hits = 0;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         if (ready_o) hits++;
      end
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      for (int k = 11; k <= 40; k++) begin
         @(negedge clk);
         if (ready_o) hits++;
      end
      check("annul_noready", 64'(hits), 64'd0);
      check("annul_keep", result_o, prev);
      run_div("u20_3", 1'b0, 32'd20, 32'd3);
      check("u20_3_val", result_o, {32'd2, 32'd6});

      // reset at E5
      signed_div_i = 1'b0;
      a = 32'd1000;
      b = 32'd3;
      start_i = 1'b1;
      for (int k = 0; k <= 4; k++) @(negedge clk);
      rst = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
      check("mrst_ready", 64'(ready_o), 64'd0);
      check("mrst_result", result_o, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      run_div("u9_3", 1'b0, 32'd9, 32'd3);
      check("u9_3_val", result_o, {32'd0, 32'd3});

      // back-to-back random divides
      for (int i = 0; i < 40; i++) begin
         logic s;
         logic [31:0] x, y;
         s = 1'($urandom_range(0, 1));
         x = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: y = 32'($urandom_range(1, 16));
            2: y = 32'hFFFFFFFF;
            3: y = $urandom >> $urandom_range(0, 31);
            default: y = $urandom;
         endcase
         if (i % 10 == 3) x = 32'h80000000;
         run_div($sformatf("rnd%0d", i), s, x, y);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
